ctrn: RTL and testbench

Parametrised step counter/accumulator, successor to the fixed 8-bit counter: on each enabled clock it adds or subtracts a step input `x` to the count `y`, or loads it. It has a programmable modulus, a terminal-count pulse and a sticky overflow flag. It sits in the same layout/gate-level flow as its predecessor: flat registered logic, one clock domain, SDF-annotatable.

---
 rtl/ctrn_if.sv | 23 ++
 rtl/ctrn.sv | 85 ++++++++
 tb/tb_ctrn.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ctrn_if.sv
// Control/status bundle for the ctrn step counter: step/load inputs toward the counter, count and flags back.
// Master drives en/mode/x/clr_ovf; slave (the counter) drives y/tc/ovf.
interface ctrn_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] x;
    logic             clr_ovf;
    logic [WIDTH-1:0] y;
    logic             tc;
    logic             ovf;

    modport master (
        output en, mode, x, clr_ovf,
        input  y, tc, ovf
    );

    modport slave (
        input  en, mode, x, clr_ovf,
        output y, tc, ovf
    );
endinterface

// File: rtl/ctrn.sv
// Modulo-(MAX+1) step counter: up/down by clamped x, load, hold; tc pulse and sticky ovf. CTRN_SAT_EN selects saturating.
// Latency: 1 cycle, all outputs registered, no input-to-output combinational path.
// No backpressure: every enabled edge is consumed; en=0 holds state.
module ctrn #(
    parameter int WIDTH = 8,
    parameter int MAX   = 2**WIDTH - 1
) (
    input  logic    clk,
    input  logic    reset,
    ctrn_if.slave   bus
);
    localparam logic [WIDTH:0]   L_MAX   = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] L_MAX_N = WIDTH'(MAX);
`ifndef CTRN_SAT_EN
    // MAX+1 may equal 2**WIDTH; modulo-2**WIDTH arithmetic still lands on the right residue.
    localparam logic [WIDTH-1:0] L_MOD_N = WIDTH'(MAX + 1);
`endif

    logic [WIDTH-1:0] r_y;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_xs;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_y_nxt;
    logic             w_tc_nxt;

    assign w_xs  = ({1'b0, bus.x} > L_MAX) ? L_MAX_N : bus.x;
    assign w_sum = {1'b0, r_y} + {1'b0, w_xs};

    always_comb begin
        w_y_nxt  = r_y;
        w_tc_nxt = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                2'b01: begin
                    if (w_sum > L_MAX) begin
`ifdef CTRN_SAT_EN
                        w_y_nxt  = L_MAX_N;
`else
                        w_y_nxt  = r_y + w_xs - L_MOD_N;
`endif
                        w_tc_nxt = 1'b1;
                    end else begin
                        w_y_nxt  = w_sum[WIDTH-1:0];
                    end
                end
                2'b10: begin
                    if (w_xs > r_y) begin
`ifdef CTRN_SAT_EN
                        w_y_nxt  = '0;
`else
                        w_y_nxt  = r_y + L_MOD_N - w_xs;
`endif
                        w_tc_nxt = 1'b1;
                    end else begin
                        w_y_nxt  = r_y - w_xs;
                    end
                end
                2'b11:   w_y_nxt = w_xs;
                default: w_y_nxt = r_y;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_y   <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_y  <= w_y_nxt;
            r_tc <= w_tc_nxt;
            // A wrap on the same edge as clr_ovf keeps the flag set.
            if (w_tc_nxt)
                r_ovf <= 1'b1;
            else if (bus.clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    assign bus.y   = r_y;
    assign bus.tc  = r_tc;
    assign bus.ovf = r_ovf;
endmodule

// File: tb/tb_ctrn.sv
// Scoreboard bench for ctrn: one DUT at MAX=255, one at MAX=9; drivers queue hand-computed results, monitors pop and compare.
// Define CTRN_SAT_EN for both RTL and bench to exercise the saturating build.
module tb_ctrn;
    typedef struct packed {
        logic [7:0] y;
        logic       tc;
        logic       ovf;
    } exp_t;

    logic clk;
    logic reset_a;
    logic reset_b;

    ctrn_if #(.WIDTH(8)) bus_a ();
    ctrn_if #(.WIDTH(8)) bus_b ();

    ctrn #(.WIDTH(8))            u_dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
    ctrn #(.WIDTH(8), .MAX(9))   u_dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
        end
    endtask

    task automatic cyc_a(input logic rst, input logic en, input logic [1:0] md, input logic [7:0] xv,
                         input logic clr, input logic [7:0] ey, input logic etc, input logic eovf);
        @(negedge clk);
        reset_a       = rst;
        bus_a.en      = en;
        bus_a.mode    = md;
        bus_a.x       = xv;
        bus_a.clr_ovf = clr;
        qa.push_back('{y: ey, tc: etc, ovf: eovf});
    endtask

    task automatic cyc_b(input logic rst, input logic en, input logic [1:0] md, input logic [7:0] xv,
                         input logic clr, input logic [7:0] ey, input logic etc, input logic eovf);
        @(negedge clk);
        reset_b       = rst;
        bus_b.en      = en;
        bus_b.mode    = md;
        bus_b.x       = xv;
        bus_b.clr_ovf = clr;
        qb.push_back('{y: ey, tc: etc, ovf: eovf});
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a.y",   bus_a.y,          e.y);
                check("a.tc",  {7'd0, bus_a.tc},  {7'd0, e.tc});
                check("a.ovf", {7'd0, bus_a.ovf}, {7'd0, e.ovf});
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b.y",   bus_b.y,          e.y);
                check("b.tc",  {7'd0, bus_b.tc},  {7'd0, e.tc});
                check("b.ovf", {7'd0, bus_b.ovf}, {7'd0, e.ovf});
            end
        end
    end

    localparam logic [1:0] HOLD = 2'b00, UP = 2'b01, DN = 2'b10, LD = 2'b11;

    initial begin
        reset_a = 1'b1; bus_a.en = 1'b0; bus_a.mode = HOLD; bus_a.x = '0; bus_a.clr_ovf = 1'b0;
        reset_b = 1'b1; bus_b.en = 1'b0; bus_b.mode = HOLD; bus_b.x = '0; bus_b.clr_ovf = 1'b0;

        for (int i = 0; i < 3; i++) cyc_a(1, 0, HOLD, 8'd0, 0, 8'd0, 0, 0);
`ifndef CTRN_SAT_EN
        // Full-range up count by 1: wraps to 0 exactly on the 256th step.
        for (int i = 1; i <= 256; i++)
            cyc_a(0, 1, UP, 8'd1, 0, 8'(i % 256), (i == 256), (i == 256));
        cyc_a(0, 0, UP,   8'd1,   1, 8'd0,   0, 0);   // clr_ovf alone
        cyc_a(0, 1, UP,   8'd255, 0, 8'd255, 0, 0);   // land exactly on MAX
        cyc_a(0, 1, UP,   8'd1,   1, 8'd0,   1, 1);   // wrap beats clr_ovf
        cyc_a(0, 0, UP,   8'd1,   0, 8'd0,   0, 1);
        cyc_a(0, 1, LD,   8'd200, 0, 8'd200, 0, 1);
        cyc_a(0, 1, UP,   8'd100, 0, 8'd44,  1, 1);
        cyc_a(0, 1, LD,   8'd200, 0, 8'd200, 0, 1);
        cyc_a(1, 1, UP,   8'd100, 0, 8'd0,   0, 0);   // reset mid-count
        cyc_a(0, 1, UP,   8'd100, 0, 8'd100, 0, 0);
        cyc_a(0, 1, DN,   8'd100, 0, 8'd0,   0, 0);   // land exactly on 0
        cyc_a(0, 1, HOLD, 8'd7,   0, 8'd0,   0, 0);
        cyc_a(0, 1, DN,   8'd0,   0, 8'd0,   0, 0);
        cyc_a(0, 1, DN,   8'd1,   0, 8'd255, 1, 1);
        cyc_a(0, 1, DN,   8'd1,   0, 8'd254, 0, 1);

        cyc_b(1, 0, HOLD, 8'd0,  0, 8'd0, 0, 0);
        cyc_b(0, 1, UP,   8'd4,  0, 8'd4, 0, 0);
        cyc_b(0, 1, UP,   8'd4,  0, 8'd8, 0, 0);
        cyc_b(0, 1, UP,   8'd4,  0, 8'd2, 1, 1);
        cyc_b(0, 1, UP,   8'd4,  0, 8'd6, 0, 1);
        cyc_b(0, 1, UP,   8'd4,  0, 8'd0, 1, 1);
        cyc_b(0, 1, UP,   8'd12, 0, 8'd9, 0, 1);      // step clamped to 9
        cyc_b(0, 1, LD,   8'd3,  0, 8'd3, 0, 1);
        cyc_b(0, 1, DN,   8'd5,  0, 8'd8, 1, 1);
        cyc_b(0, 1, DN,   8'd5,  0, 8'd3, 0, 1);
        cyc_b(0, 1, DN,   8'd5,  0, 8'd8, 1, 1);
        cyc_b(0, 0, DN,   8'd5,  0, 8'd8, 0, 1);
        cyc_b(0, 0, DN,   8'd5,  0, 8'd8, 0, 1);
        cyc_b(0, 1, LD,   8'd15, 0, 8'd9, 0, 1);      // load clamped to 9
        cyc_b(0, 0, LD,   8'd0,  1, 8'd9, 0, 0);
        cyc_b(0, 1, UP,   8'd1,  0, 8'd0, 1, 1);
`else
        cyc_a(0, 1, LD,   8'd250, 0, 8'd250, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc_a(0, 1, UP, 8'd10, 0, 8'd255, 1, 1);
        cyc_a(0, 1, UP,   8'd0,   0, 8'd255, 0, 1);
        cyc_a(0, 1, DN,   8'd255, 0, 8'd0,   0, 1);
        cyc_a(0, 1, DN,   8'd255, 0, 8'd0,   1, 1);
        cyc_a(0, 0, DN,   8'd255, 1, 8'd0,   0, 0);
        cyc_a(0, 1, DN,   8'd1,   1, 8'd0,   1, 1);   // clamp beats clr_ovf
        cyc_a(0, 1, LD,   8'd9,   0, 8'd9,   0, 1);
        cyc_a(1, 1, UP,   8'd5,   0, 8'd0,   0, 0);
        cyc_a(0, 1, UP,   8'd5,   0, 8'd5,   0, 0);

        cyc_b(1, 0, HOLD, 8'd0,  0, 8'd0, 0, 0);
        cyc_b(0, 1, LD,   8'd7,  0, 8'd7, 0, 0);
        cyc_b(0, 1, UP,   8'd4,  0, 8'd9, 1, 1);
        cyc_b(0, 1, UP,   8'd20, 0, 8'd9, 1, 1);
        cyc_b(0, 1, DN,   8'd9,  0, 8'd0, 0, 1);
`endif
        @(negedge clk);
        @(negedge clk);
        check("a.queue_left", 8'(qa.size()), 8'd0);
        check("b.queue_left", 8'(qb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
